dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
- Sequences all accesses to the 512-byte big-endian data memory (enable-edge-triggered, Size/SignExtend controlled) and shares it between two requesters.
- Port A is the load/store unit; port B is the debug/loader port.
- Checks SPARC alignment rules before touching memory and drives the memory's Enable/ReadWrite/Address/Size/SignExtend with clean setup/strobe/release timing.
- Returns read data and an ack/error pulse to the granted requester.

Parameters:
- MEM_LAT, 1, cycles mem_enable is held high per access (1..15); read data is captured on the last of these cycles.
- ADDR_W, 9, byte address width.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- a_req, b_req  in  1  request, held until ack
- a_rw, b_rw  in  1  1 = write, 0 = read
- a_addr, b_addr  in  ADDR_W  byte address
- a_wdata, b_wdata  in  32  write data, right-justified
- a_size, b_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- a_sext, b_sext  in  1  sign-extend on read
- a_ack, b_ack  out  1  one-cycle completion pulse
- a_err, b_err  out  1  asserted with ack on a rejected request
- a_rdata, b_rdata  out  32  read result, updated at successful read ack, held otherwise
- mem_enable  out  1  memory strobe
- mem_rw  out  1  memory ReadWrite
- mem_addr  out  ADDR_W  memory Address
- mem_din  out  32  memory DataIn
- mem_size  out  2  memory Size
- mem_sext  out  2  memory SignExtend, driven as {1'b0, sext}
- mem_dout  in  32  memory DataOut
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous):
  - State goes to IDLE.
  - All outputs go to 0, including rdata registers and mem_enable.
  - last_grant is set to B, so A wins the first conflict.
  - A reset during ACCESS drops mem_enable immediately. The in-flight request is discarded with no ack; the requester reissues it.
- FSM states: IDLE, CHECK, SETUP, ACCESS, DONE, ERR.
- IDLE:
  - Samples a_req and b_req.
  - Only one requesting: that port is granted.
  - Both requesting: the port other than last_grant is granted (round-robin).
  - The granted port's rw/addr/wdata/size/sext are latched into internal registers. Requester inputs are ignored after this point.
  - Next state is CHECK.
- CHECK: request is illegal if size==11, or (size==01 and addr[0]), or (size==10 and addr[1:0]!=0).
  - Illegal: go to ERR.
  - Legal: go to SETUP.
- ERR:
  - One cycle with ack and err pulsed on the granted port.
  - rdata is unchanged and mem_enable is never raised.
  - last_grant is updated. Next state is IDLE.
- SETUP:
  - mem_rw/addr/din/size/sext are driven from the latched request; mem_enable stays 0.
  - These mem_* values stay stable through ACCESS and DONE.
- ACCESS:
  - mem_enable=1 for exactly MEM_LAT cycles, counted by a 4-bit down-counter.
  - On the final ACCESS cycle of a read, mem_dout is captured into the granted port's rdata.
- DONE:
  - mem_enable=0 and ack pulsed on the granted port with err=0.
  - last_grant is updated. Next state is IDLE.
- Latency from the IDLE sampling edge:
  - Legal request: ack at cycle MEM_LAT+3.
  - Illegal request: ack at cycle 2.
- Back-to-back: the requester must drop req the cycle after ack. A req still high in IDLE is treated as a new request.
- The non-granted port sees ack=0 and rdata unchanged throughout.
- Only one access is outstanding at a time; no pipelining.
- mem_enable rises only after at least one SETUP cycle with stable address/control, and falls before the controller returns to IDLE.
- Address arithmetic: no wrap check. Word/half at aligned addresses never cross 511.

Test Plan:
- A word write, addr 0x010, wdata 0xDEADBEEF, MEM_LAT=1 -> mem_size=10, mem_enable high exactly 1 cycle, a_ack at cycle 4, a_err=0.
- A byte read with sext=1 at 0x010 after the previous write -> mem_sext=01, a_rdata=0xFFFFFFDE. Same read with sext=0 -> 0x000000DE.
- a_req and b_req both high at reset release, both reads -> A served first, then B. A second simultaneous pair -> B served first. Neither port's rdata is corrupted by the other.
- B half read at 0x011, and separately size=11 at 0x020 -> b_ack and b_err at cycle 2, mem_enable never asserted, b_rdata unchanged.
- reset pulsed during ACCESS with MEM_LAT=4 -> mem_enable=0 and busy=0 immediately, no ack. A fresh request afterwards completes at cycle 7.
- A issues 3 consecutive word reads 0x000/0x004/0x008 while B holds req -> grants alternate A,B,A,B and every ack carries correct data.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: arbitrates two requesters (A = load/store unit,
// B = debug/loader) onto a single 512-byte big-endian data memory. Each
// request is alignment-checked, then the memory strobe is driven with a
// setup cycle, MEM_LAT strobe cycles and a release cycle.
//
// Handshake: a requester raises req with rw/addr/wdata/size/sext stable and
// holds it until it sees a one-cycle ack (with err on rejection); it must
// drop req the cycle after ack. A req still high in IDLE is a new request.
module dmem_access_ctrl #(
  parameter int MEM_LAT = 1,
  parameter int ADDR_W  = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_rw,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [31:0]       a_wdata,
  input  logic [1:0]        a_size,
  input  logic              a_sext,
  input  logic              b_req,
  input  logic              b_rw,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [31:0]       b_wdata,
  input  logic [1:0]        b_size,
  input  logic              b_sext,
  output logic              a_ack,
  output logic              a_err,
  output logic [31:0]       a_rdata,
  output logic              b_ack,
  output logic              b_err,
  output logic [31:0]       b_rdata,
  output logic              mem_enable,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic [1:0]        mem_size,
  output logic [1:0]        mem_sext,
  input  logic [31:0]       mem_dout,
  output logic              busy,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_SETUP  = 3'd2,
    S_ACCESS = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  localparam logic [3:0] LAT = 4'(MEM_LAT);
  localparam logic       GRANT_A = 1'b0;
  localparam logic       GRANT_B = 1'b1;

  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        size_q, size_d;
  logic              sext_q, sext_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       a_rdata_q, a_rdata_d;
  logic [31:0]       b_rdata_q, b_rdata_d;
  logic              illegal;

  // SPARC alignment: halfwords on even, words on 4-byte boundaries; size 11 never legal.
  assign illegal = (size_q == 2'b11) ||
                   ((size_q == 2'b01) && addr_q[0]) ||
                   ((size_q == 2'b10) && (addr_q[1:0] != 2'b00));

  // State and datapath registers; reset drops the strobe and discards any in-flight request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      grant_q      <= GRANT_A;
      last_grant_q <= GRANT_B;
      rw_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      size_q       <= 2'b00;
      sext_q       <= 1'b0;
      cnt_q        <= 4'd0;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      rw_q         <= rw_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      size_q       <= size_d;
      sext_q       <= sext_d;
      cnt_q        <= cnt_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
    end
  end

  // Next-state logic: round-robin grant, request latch, strobe counter, read capture.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    rw_d         = rw_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    size_d       = size_q;
    sext_d       = sext_q;
    cnt_d        = cnt_q;
    a_rdata_d    = a_rdata_q;
    b_rdata_d    = b_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (a_req || b_req) begin
          // On conflict the port that did not win last time goes first.
          grant_d = (a_req && b_req) ? ~last_grant_q : b_req;
          if (grant_d == GRANT_B) begin
            rw_d    = b_rw;
            addr_d  = b_addr;
            wdata_d = b_wdata;
            size_d  = b_size;
            sext_d  = b_sext;
          end else begin
            rw_d    = a_rw;
            addr_d  = a_addr;
            wdata_d = a_wdata;
            size_d  = a_size;
            sext_d  = a_sext;
          end
          state_d = S_CHECK;
        end
      end
      S_CHECK: state_d = illegal ? S_ERR : S_SETUP;
      S_SETUP: begin
        cnt_d   = LAT;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (cnt_q <= 4'd1) begin
          if (!rw_q) begin
            if (grant_q == GRANT_B) b_rdata_d = mem_dout;
            else                    a_rdata_d = mem_dout;
          end
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE, S_ERR: begin
        last_grant_d = grant_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state; memory controls held from SETUP through DONE.
  always_comb begin
    a_ack      = 1'b0;
    a_err      = 1'b0;
    b_ack      = 1'b0;
    b_err      = 1'b0;
    mem_enable = 1'b0;
    mem_rw     = 1'b0;
    mem_addr   = '0;
    mem_din    = '0;
    mem_size   = 2'b00;
    mem_sext   = 2'b00;
    if ((state_q == S_SETUP) || (state_q == S_ACCESS) || (state_q == S_DONE)) begin
      mem_rw   = rw_q;
      mem_addr = addr_q;
      mem_din  = wdata_q;
      mem_size = size_q;
      mem_sext = {1'b0, sext_q};
    end
    if (state_q == S_ACCESS) mem_enable = 1'b1;
    if ((state_q == S_DONE) || (state_q == S_ERR)) begin
      if (grant_q == GRANT_B) begin
        b_ack = 1'b1;
        b_err = (state_q == S_ERR);
      end else begin
        a_ack = 1'b1;
        a_err = (state_q == S_ERR);
      end
    end
  end

  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
  assign busy      = (state_q != S_IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: one instance with MEM_LAT=1 for the
// functional sequence and one with MEM_LAT=4 for the reset-during-access case.
// A behavioural big-endian memory (byte i preloaded with i[7:0]) serves both.
module tb_dmem_access_ctrl;
  localparam int AW = 9;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst4 = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT (MEM_LAT=1) ----------------
  logic a_req, a_rw, a_sext, b_req, b_rw, b_sext;
  logic [AW-1:0] a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata;
  logic [1:0] a_size, b_size;
  logic a_ack, a_err, b_ack, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic m_en, m_rw, busy;
  logic [AW-1:0] m_addr;
  logic [31:0] m_din, m_dout;
  logic [1:0] m_size, m_sext;
  logic [2:0] st;

  dmem_access_ctrl #(.MEM_LAT(1), .ADDR_W(AW)) u_dut (
    .clk(clk), .reset(rst),
    .a_req(a_req), .a_rw(a_rw), .a_addr(a_addr), .a_wdata(a_wdata), .a_size(a_size), .a_sext(a_sext),
    .b_req(b_req), .b_rw(b_rw), .b_addr(b_addr), .b_wdata(b_wdata), .b_size(b_size), .b_sext(b_sext),
    .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
    .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
    .mem_enable(m_en), .mem_rw(m_rw), .mem_addr(m_addr), .mem_din(m_din),
    .mem_size(m_size), .mem_sext(m_sext), .mem_dout(m_dout),
    .busy(busy), .state_dbg(st)
  );

  // ---------------- DUT (MEM_LAT=4), port A only ----------------
  logic d_req;
  logic [AW-1:0] d_addr;
  logic d_ack, d_err, d_b_ack, d_b_err;
  logic [31:0] d_rdata, d_b_rdata;
  logic d_en, d_rw, d_busy;
  logic [AW-1:0] d_maddr;
  logic [31:0] d_din, d_dout;
  logic [1:0] d_size, d_sext;
  logic [2:0] d_st;
  logic [AW-1:0] zero_addr = '0;
  logic [31:0] zero_w = '0;
  logic [1:0] zero_s = 2'b00;
  logic zero_b = 1'b0;
  logic [1:0] word_s = 2'b10;

  dmem_access_ctrl #(.MEM_LAT(4), .ADDR_W(AW)) u_dut4 (
    .clk(clk), .reset(rst4),
    .a_req(d_req), .a_rw(zero_b), .a_addr(d_addr), .a_wdata(zero_w), .a_size(word_s), .a_sext(zero_b),
    .b_req(zero_b), .b_rw(zero_b), .b_addr(zero_addr), .b_wdata(zero_w), .b_size(zero_s), .b_sext(zero_b),
    .a_ack(d_ack), .a_err(d_err), .a_rdata(d_rdata),
    .b_ack(d_b_ack), .b_err(d_b_err), .b_rdata(d_b_rdata),
    .mem_enable(d_en), .mem_rw(d_rw), .mem_addr(d_maddr), .mem_din(d_din),
    .mem_size(d_size), .mem_sext(d_sext), .mem_dout(d_dout),
    .busy(d_busy), .state_dbg(d_st)
  );

  // ---------------- behavioural memory (enable-edge triggered) ----------------
  logic [7:0] mem [0:511];
  initial for (int i = 0; i < 512; i++) mem[i] = i[7:0];
  initial begin m_dout = '0; d_dout = '0; end

  function automatic logic [31:0] mem_rd(input logic [AW-1:0] ad, input logic [1:0] sz, input logic sx);
    logic [31:0] r;
    case (sz)
      2'b00:   r = sx ? {{24{mem[ad][7]}}, mem[ad]} : {24'h0, mem[ad]};
      2'b01: begin
        r = {16'h0, mem[ad], mem[AW'(ad + 1)]};
        if (sx) r[31:16] = {16{mem[ad][7]}};
      end
      default: r = {mem[ad], mem[AW'(ad + 1)], mem[AW'(ad + 2)], mem[AW'(ad + 3)]};
    endcase
    return r;
  endfunction

  always @(posedge m_en) begin
    if (m_rw) begin
      case (m_size)
        2'b00: mem[m_addr] = m_din[7:0];
        2'b01: begin mem[m_addr] = m_din[15:8]; mem[AW'(m_addr + 1)] = m_din[7:0]; end
        default: begin
          mem[m_addr] = m_din[31:24];           mem[AW'(m_addr + 1)] = m_din[23:16];
          mem[AW'(m_addr + 2)] = m_din[15:8];   mem[AW'(m_addr + 3)] = m_din[7:0];
        end
      endcase
    end else begin
      m_dout = mem_rd(m_addr, m_size, m_sext[0]);
    end
  end

  always @(posedge d_en) d_dout = mem_rd(d_maddr, d_size, d_sext[0]);

  // Strobe monitor: counts enable-high cycles and records the controls seen during the strobe.
  int en_cnt = 0;
  logic [1:0] cap_size = 2'b00;
  logic [1:0] cap_sext = 2'b00;
  always @(negedge clk) begin
    if (m_en) begin
      en_cnt++;
      cap_size = m_size;
      cap_sext = m_sext;
    end
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [32:0] exp_q[$];

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_ack(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(a_ack || b_ack) && n < 100);
  endtask

  // Single transaction on an idle controller; lat counts from the IDLE sampling edge.
  task automatic xact(input logic port, input logic rw, input logic [AW-1:0] ad, input logic [31:0] wd,
                      input logic [1:0] sz, input logic sx, output int lat);
    @(negedge clk);
    en_cnt = 0;
    if (!port) begin
      a_req = 1'b1; a_rw = rw; a_addr = ad; a_wdata = wd; a_size = sz; a_sext = sx;
    end else begin
      b_req = 1'b1; b_rw = rw; b_addr = ad; b_wdata = wd; b_size = sz; b_sext = sx;
    end
    @(posedge clk);
    lat = 0;
    while (lat < 50) begin
      @(negedge clk);
      lat++;
      if (a_ack || b_ack) break;
    end
    a_req = 1'b0;
    b_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    int a_idx;
    int b_cnt;
    logic a_re, b_re;
    logic [32:0] got;

    // Both ports request word reads while reset is held.
    a_req = 1'b1; a_rw = 1'b0; a_addr = 9'h004; a_wdata = '0; a_size = 2'b10; a_sext = 1'b0;
    b_req = 1'b1; b_rw = 1'b0; b_addr = 9'h008; b_wdata = '0; b_size = 2'b10; b_sext = 1'b0;
    d_req = 1'b0; d_addr = '0;
    repeat (2) @(negedge clk);
    check("rst_acks", {29'd0, a_ack, b_ack, a_err, b_err}, 33'd0);
    check("rst_a_rdata", {1'b0, a_rdata}, 33'd0);
    check("rst_b_rdata", {1'b0, b_rdata}, 33'd0);
    check("rst_en_busy", {31'd0, m_en, busy}, 33'd0);
    rst = 1'b0;
    rst4 = 1'b0;

    // First conflict: A wins.
    wait_ack(lat);
    check("pair1_first_is_a", {31'd0, a_ack, b_ack}, 33'b10);
    check("pair1_a_rdata", {1'b0, a_rdata}, {1'b0, 32'h04050607});
    check("pair1_b_untouched", {1'b0, b_rdata}, 33'd0);
    a_req = 1'b0;
    wait_ack(lat);
    check("pair1_second_is_b", {31'd0, a_ack, b_ack}, 33'b01);
    check("pair1_b_rdata", {1'b0, b_rdata}, {1'b0, 32'h08090A0B});
    check("pair1_a_kept", {1'b0, a_rdata}, {1'b0, 32'h04050607});
    b_req = 1'b0;

    // Word write 0xDEADBEEF at 0x010.
    xact(1'b0, 1'b1, 9'h010, 32'hDEADBEEF, 2'b10, 1'b0, lat);
    check("wr_latency", 33'(lat), 33'd4);
    check("wr_en_cycles", 33'(en_cnt), 33'd1);
    check("wr_mem_size", {31'd0, cap_size}, 33'b10);
    check("wr_ack_err", {31'd0, a_ack, a_err}, 33'b10);

    // Byte reads of 0x010 (0xDE) with and without sign extension.
    xact(1'b0, 1'b0, 9'h010, 32'h0, 2'b00, 1'b1, lat);
    check("rdb_sext_latency", 33'(lat), 33'd4);
    check("rdb_sext_mem_sext", {31'd0, cap_sext}, 33'b01);
    check("rdb_sext_rdata", {1'b0, a_rdata}, {1'b0, 32'hFFFFFFDE});
    xact(1'b0, 1'b0, 9'h010, 32'h0, 2'b00, 1'b0, lat);
    check("rdb_zext_mem_sext", {31'd0, cap_sext}, 33'b00);
    check("rdb_zext_rdata", {1'b0, a_rdata}, {1'b0, 32'h000000DE});

    // Second conflict after an A-only access: B wins.
    @(negedge clk);
    a_req = 1'b1; a_rw = 1'b0; a_addr = 9'h000; a_size = 2'b10; a_sext = 1'b0;
    b_req = 1'b1; b_rw = 1'b0; b_addr = 9'h014; b_size = 2'b10; b_sext = 1'b0;
    wait_ack(lat);
    check("pair2_first_is_b", {31'd0, a_ack, b_ack}, 33'b01);
    check("pair2_b_rdata", {1'b0, b_rdata}, {1'b0, 32'h14151617});
    check("pair2_a_kept", {1'b0, a_rdata}, {1'b0, 32'h000000DE});
    b_req = 1'b0;
    wait_ack(lat);
    check("pair2_second_is_a", {31'd0, a_ack, b_ack}, 33'b10);
    check("pair2_a_rdata", {1'b0, a_rdata}, {1'b0, 32'h00010203});
    check("pair2_b_kept", {1'b0, b_rdata}, {1'b0, 32'h14151617});
    a_req = 1'b0;

    // Misaligned half and illegal size on B: rejected without a strobe.
    xact(1'b1, 1'b0, 9'h011, 32'h0, 2'b01, 1'b0, lat);
    check("mis_half_latency", 33'(lat), 33'd2);
    check("mis_half_ack_err", {30'd0, a_ack, b_ack, b_err}, 33'b011);
    check("mis_half_no_en", 33'(en_cnt), 33'd0);
    check("mis_half_rdata", {1'b0, b_rdata}, {1'b0, 32'h14151617});
    xact(1'b1, 1'b0, 9'h020, 32'h0, 2'b11, 1'b0, lat);
    check("size11_latency", 33'(lat), 33'd2);
    check("size11_ack_err", {30'd0, a_ack, b_ack, b_err}, 33'b011);
    check("size11_no_en", 33'(en_cnt), 33'd0);
    check("size11_rdata", {1'b0, b_rdata}, {1'b0, 32'h14151617});

    // A: three word reads 0x000/0x004/0x008; B keeps requesting 0x00C.
    exp_q.push_back({1'b0, 32'h00010203});
    exp_q.push_back({1'b1, 32'h0C0D0E0F});
    exp_q.push_back({1'b0, 32'h04050607});
    exp_q.push_back({1'b1, 32'h0C0D0E0F});
    exp_q.push_back({1'b0, 32'h08090A0B});
    exp_q.push_back({1'b1, 32'h0C0D0E0F});
    @(negedge clk);
    a_req = 1'b1; a_rw = 1'b0; a_addr = 9'h000; a_size = 2'b10; a_sext = 1'b0;
    b_req = 1'b1; b_rw = 1'b0; b_addr = 9'h00C; b_size = 2'b10; b_sext = 1'b0;
    a_idx = 0; b_cnt = 0; a_re = 1'b0; b_re = 1'b0;
    for (int cyc = 0; cyc < 300 && exp_q.size() > 0; cyc++) begin
      @(negedge clk);
      if (a_re) begin a_req = 1'b1; a_addr = AW'(a_idx * 4); a_re = 1'b0; end
      if (b_re) begin b_req = 1'b1; b_re = 1'b0; end
      if (a_ack || b_ack) begin
        got = a_ack ? {1'b0, a_rdata} : {1'b1, b_rdata};
        check("rr_grant_data", got, exp_q.pop_front());
        if (a_ack) begin
          a_req = 1'b0; a_idx++; a_re = (a_idx < 3);
        end else begin
          b_req = 1'b0; b_cnt++; b_re = (b_cnt < 3);
        end
      end
    end
    check("rr_all_served", 33'(exp_q.size()), 33'd0);

    // MEM_LAT=4 instance: reset in the middle of the strobe.
    @(negedge clk);
    d_req = 1'b1; d_addr = 9'h004;
    lat = 0;
    while (!d_en && lat < 20) begin @(negedge clk); lat++; end
    check("lat4_strobe_seen", {32'd0, d_en}, 33'd1);
    @(negedge clk);
    rst4 = 1'b1;
    #1;
    check("lat4_rst_en_busy", {31'd0, d_en, d_busy}, 33'd0);
    check("lat4_rst_no_ack", {32'd0, d_ack}, 33'd0);
    @(negedge clk);
    rst4 = 1'b0;
    @(posedge clk);
    lat = 0;
    while (lat < 50) begin
      @(negedge clk);
      lat++;
      if (d_ack) break;
    end
    check("lat4_reissue_latency", 33'(lat), 33'd7);
    check("lat4_reissue_rdata", {1'b0, d_rdata}, {1'b0, 32'h04050607});
    check("lat4_reissue_err", {32'd0, d_err}, 33'd0);
    d_req = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
